row_swap_ctrl: RTL

// - Miss-service engine for the emulation-memory row cache. Consumes the cache's miss `hold`.
// - Writes back the dirty victim row to host memory and fetches the missing row into the freed slot.
// - Pulses `sync` so the cache leaves RDMiss/WRMiss. Sits between the row cache and the host-memory burst port.

---
 rtl/dram_emu_pkg.sv | 22 ++
 rtl/row_swap_watchdog.sv | 36 +++
 rtl/row_swap_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dram_emu_pkg.sv
// Types and default widths shared by the emulation-memory row cache and its miss-service engine.
package dram_emu_pkg;

    localparam int DEF_CHWIDTH   = 5;
    localparam int DEF_ADDRWIDTH = 17;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_REQ    = 3'd1,
        S_WB_XFER   = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_XFER = 3'd4,
        S_DONE      = 3'd5,
        S_DRAIN     = 3'd6
    } swap_state_t;

    typedef enum logic {
        OP_FILL = 1'b0,
        OP_WB   = 1'b1
    } swap_op_t;

endpackage

// File: rtl/row_swap_watchdog.sv
// Stall watchdog for the row-swap engine: counts cycles without host progress and raises a sticky error.
module row_swap_watchdog #(
    parameter int TOWIDTH = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic progress_i,
    output logic timeout_o,
    output logic err_o
);

    // Fires on the (2**TOWIDTH-1)-th consecutive stalled cycle.
    localparam logic [TOWIDTH-1:0] LAST_STALL = {{(TOWIDTH-1){1'b1}}, 1'b0};

    logic [TOWIDTH-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               stall;

    assign stall     = active_i && !progress_i;
    assign timeout_o = stall && (cnt_q == LAST_STALL);
    assign cnt_d     = (stall && !timeout_o) ? cnt_q + TOWIDTH'(1) : '0;
    assign err_d     = err_q || timeout_o;
    assign err_o     = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/row_swap_ctrl.sv
// Row-cache miss service: optional victim writeback, then row fill, then a one-cycle sync/tag_upd release.
// Define ROW_SWAP_TIMEOUT_EN to add the host-stall watchdog and sticky err flag.
module row_swap_ctrl #(
    parameter int CHWIDTH   = dram_emu_pkg::DEF_CHWIDTH,
    parameter int ADDRWIDTH = dram_emu_pkg::DEF_ADDRWIDTH,
    parameter int BEATWIDTH = 4,
    parameter int TOWIDTH   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [ADDRWIDTH-1:0] miss_row,
    input  logic [CHWIDTH-1:0]   vic_slot,
    input  logic [ADDRWIDTH-1:0] vic_row,
    input  logic                 vic_dirty,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_row,
    output logic [CHWIDTH-1:0]   mem_slot,
    input  logic                 mem_gnt,
    input  logic                 beat_valid,
    output logic [BEATWIDTH-1:0] beat_idx,
    output logic                 tag_upd,
    output logic                 sync,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           state_dbg
);
    import dram_emu_pkg::*;

    swap_state_t          state_q;
    swap_op_t             op_q;
    logic [ADDRWIDTH-1:0] miss_row_q;
    logic [ADDRWIDTH-1:0] mem_row_q;
    logic [CHWIDTH-1:0]   vic_slot_q;
    logic [BEATWIDTH-1:0] beat_q, beat_d;
    logic                 mem_req_q;
    logic                 sync_q;
    logic                 tag_upd_q;
    logic                 timeout;
    logic                 in_req, in_xfer;

    assign beat_d  = beat_q + BEATWIDTH'(1);
    assign in_req  = (state_q == S_WB_REQ) || (state_q == S_FILL_REQ);
    assign in_xfer = (state_q == S_WB_XFER) || (state_q == S_FILL_XFER);

`ifdef ROW_SWAP_TIMEOUT_EN
    row_swap_watchdog #(.TOWIDTH(TOWIDTH)) u_watchdog (
        .clk_i      (clk),
        .rst_i      (rst),
        .active_i   (in_req || in_xfer),
        .progress_i ((in_req && mem_gnt) || (in_xfer && beat_valid)),
        .timeout_o  (timeout),
        .err_o      (err)
    );
`else
    logic [TOWIDTH-1:0] unused_towidth;
    assign unused_towidth = '0;
    assign timeout        = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_FILL;
            miss_row_q <= '0;
            mem_row_q  <= '0;
            vic_slot_q <= '0;
            beat_q     <= '0;
            mem_req_q  <= 1'b0;
            sync_q     <= 1'b0;
            tag_upd_q  <= 1'b0;
        end else begin
            sync_q    <= 1'b0;
            tag_upd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hold) begin
                        miss_row_q <= miss_row;
                        vic_slot_q <= vic_slot;
                        beat_q     <= '0;
                        mem_req_q  <= 1'b1;
                        if (vic_dirty) begin
                            state_q   <= S_WB_REQ;
                            op_q      <= OP_WB;
                            mem_row_q <= vic_row;
                        end else begin
                            state_q   <= S_FILL_REQ;
                            op_q      <= OP_FILL;
                            mem_row_q <= miss_row;
                        end
                    end
                end
                S_WB_REQ, S_FILL_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= (state_q == S_WB_REQ) ? S_WB_XFER : S_FILL_XFER;
                    end
                end
                S_WB_XFER, S_FILL_XFER: begin
                    if (beat_valid) begin
                        beat_q <= beat_d;
                        if (beat_q == {BEATWIDTH{1'b1}}) begin
                            if (state_q == S_WB_XFER) begin
                                state_q   <= S_FILL_REQ;
                                op_q      <= OP_FILL;
                                mem_row_q <= miss_row_q;
                                mem_req_q <= 1'b1;
                            end else begin
                                state_q   <= S_DONE;
                                sync_q    <= 1'b1;
                                tag_upd_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE:  state_q <= S_DRAIN;
                // Cache still shows the serviced miss on hold this cycle.
                S_DRAIN: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            // Watchdog abort: release the cache but leave its tags untouched.
            if (timeout) begin
                state_q   <= S_DONE;
                mem_req_q <= 1'b0;
                beat_q    <= '0;
                sync_q    <= 1'b1;
                tag_upd_q <= 1'b0;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = (op_q == OP_WB);
    assign mem_row   = mem_row_q;
    assign mem_slot  = vic_slot_q;
    assign beat_idx  = beat_q;
    assign tag_upd   = tag_upd_q;
    assign sync      = sync_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule
